// File: rtl/apc_accum_if.sv
// -----------------------------------------------------------------------------
// apc_accum_if -- job, stream and result signals of the APC accumulator.
//
// Groups everything except clk/rst_n into one bundle so the accumulator and
// whatever drives it see the same set of signals.
//
// Signals:
//   start       job request, sampled only while the accumulator is idle
//   len         beat count of the job, captured with start (0 = no job)
//   abort       synchronous job cancel, wins over every other request
//   in_valid    apc_stream carries a beat
//   in_ready    accumulator takes a beat this cycle
//   apc_stream  N_IN parallel stochastic bits of one beat
//   busy        a job is being counted (RUN or DRAIN)
//   out_valid   result is final and waiting to be consumed
//   out_ready   consumer takes the result
//   result      accumulated ones count (readable in every state)
//   overflow    sticky saturation flag of the current/last job
//
// Modports:
//   master  the side that issues jobs and beats and consumes the result
//   slave   the accumulator
// -----------------------------------------------------------------------------
interface apc_accum_if #(
  parameter int N_IN  = 15,
  parameter int LEN_W = 8,
  parameter int ACC_W = 12
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  apc_stream;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport master (
    output start, len, abort, in_valid, apc_stream, out_ready,
    input  in_ready, busy, out_valid, result, overflow
  );

  modport slave (
    input  start, len, abort, in_valid, apc_stream, out_ready,
    output in_ready, busy, out_valid, result, overflow
  );

endinterface : apc_accum_if

// File: rtl/apc_accum.sv
// -----------------------------------------------------------------------------
// apc_accum -- approximate parallel counter (APC) accumulator.
//
// Counts the ones in a stochastic bit stream delivered N_IN bits per beat.
// A job is started with a beat count; every accepted beat is popcounted
// (stage 1, registered into pc_reg) and the popcount is added into a
// saturating accumulator on the following edge (stage 2). Once the last beat
// has been accepted the FSM spends one DRAIN cycle letting the final popcount
// reach the accumulator, then presents the sum in DONE until it is consumed.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    apc_accum_if.slave: start/len/abort job control, in_valid/
//          in_ready/apc_stream beat handshake, out_valid/out_ready/result/
//          overflow result handshake, busy status
//
// Parameters:
//   N_IN   stochastic bits per beat (1..64)
//   CNT_W  popcount width, ceil(log2(N_IN+1))
//   LEN_W  width of the beat-count field
//   ACC_W  accumulator / result width (must be >= CNT_W)
// -----------------------------------------------------------------------------
module apc_accum #(
  parameter int N_IN  = 15,
  parameter int CNT_W = 4,
  parameter int LEN_W = 8,
  parameter int ACC_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  apc_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [LEN_W-1:0] beat_cnt;   // beats still to be accepted
  logic [CNT_W-1:0] pc_comb;    // popcount of the beat on apc_stream
  logic [CNT_W-1:0] pc_reg;     // stage-1 popcount register
  logic             pc_vld;     // pc_reg holds a popcount not yet added
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;        // one extra bit to detect saturation

  logic             accept;
  logic             job_load;
  logic             last_beat;

  // ---------------------------------------------------------------------------
  // Control decodes. abort masks both job start and beat acceptance so that a
  // cancelled cycle leaves no trace in the counter or the pipeline.
  // ---------------------------------------------------------------------------
  assign accept    = bus.in_valid && (state == RUN) && !bus.abort;
  assign job_load  = (state == IDLE) && bus.start && (bus.len != '0) && !bus.abort;
  assign last_beat = accept && (beat_cnt == LEN_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (job_load)  state_nxt = RUN;
        RUN:     if (last_beat) state_nxt = DRAIN;
        DRAIN:                  state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Beat counter. Loaded with len and only ever decremented by an accepted
  // beat; the transition to DRAIN happens at 1 -> 0, so a full-scale len never
  // wraps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (bus.abort) begin
      beat_cnt <= '0;
    end else if (job_load) begin
      beat_cnt <= bus.len;
    end else if (accept) begin
      beat_cnt <= beat_cnt - LEN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: popcount of the offered beat, registered only when accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_comb = '0;
    for (int i = 0; i < N_IN; i++) begin
      pc_comb = pc_comb + CNT_W'(bus.apc_stream[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
      pc_vld <= 1'b0;
    end else if (bus.abort) begin
      pc_reg <= '0;
      pc_vld <= 1'b0;
    end else begin
      pc_vld <= accept;
      if (accept) pc_reg <= pc_comb;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating accumulate. The last popcount arrives here during the
  // DRAIN cycle; pc_vld is never set in IDLE, so a job load and an add cannot
  // coincide.
  // ---------------------------------------------------------------------------
  assign sum = {1'b0, acc} + (ACC_W + 1)'(pc_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (bus.abort || job_load) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (pc_vld) begin
      if (sum[ACC_W]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so they are all 0 in reset.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state == RUN);
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = acc;
  assign bus.overflow  = ovf;

endmodule : apc_accum

// File: tb/tb_apc_accum.sv
// -----------------------------------------------------------------------------
// tb_apc_accum -- directed, table-driven bench for apc_accum.
//
// dut0 uses the default parameters; dut1 has ACC_W=6 to reach saturation.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_apc_accum;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  apc_accum_if #(.N_IN(15), .LEN_W(8), .ACC_W(12)) bus0 ();
  apc_accum_if #(.N_IN(15), .LEN_W(8), .ACC_W(6))  bus1 ();

  apc_accum #(.N_IN(15), .CNT_W(4), .LEN_W(8), .ACC_W(12)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  apc_accum #(.N_IN(15), .CNT_W(4), .LEN_W(8), .ACC_W(6)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          len;
    logic [59:0] beats;     // beat i at [i*15 +: 15], reused modulo 4
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full job on dut0: start, len beats back-to-back, DRAIN, DONE, consume.
  // A beat stays offered through DRAIN and DONE and must be refused.
  task automatic run_job0(input int len, input logic [59:0] beats,
                          input logic [31:0] exp_res, input logic exp_ovf);
    bus0.len   = 8'(len);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("job busy after start", 32'(bus0.busy), 32'd1);
    check("job acc cleared", 32'(bus0.result), 32'd0);
    for (int i = 0; i < len; i++) begin
      bus0.apc_stream = beats[(i % 4) * 15 +: 15];
      bus0.in_valid   = 1'b1;
      tick();
    end
    bus0.apc_stream = 15'h7FFF;
    check("drain out_valid low", 32'(bus0.out_valid), 32'd0);
    check("drain in_ready low", 32'(bus0.in_ready), 32'd0);
    tick();
    check("done out_valid", 32'(bus0.out_valid), 32'd1);
    check("done busy low", 32'(bus0.busy), 32'd0);
    check("done result", 32'(bus0.result), exp_res);
    check("done overflow", 32'(bus0.overflow), 32'(exp_ovf));
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    check("consumed out_valid low", 32'(bus0.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Popcounts: 7FFF=15, 0001=1, 00FF=8, 5555=8, 2AAA=7, 1234=5, 7000=3, 0F0F=8
    vecs[0] = '{len: 3,   beats: {15'h0000, 15'h0000, 15'h0001, 15'h7FFF}, exp_res: 32'd16,  exp_ovf: 1'b0};
    vecs[1] = '{len: 1,   beats: {15'h0000, 15'h0000, 15'h0000, 15'h00FF}, exp_res: 32'd8,   exp_ovf: 1'b0};
    vecs[2] = '{len: 2,   beats: {15'h0000, 15'h0000, 15'h2AAA, 15'h5555}, exp_res: 32'd15,  exp_ovf: 1'b0};
    vecs[3] = '{len: 4,   beats: {15'h0000, 15'h0F0F, 15'h7000, 15'h1234}, exp_res: 32'd16,  exp_ovf: 1'b0};
    vecs[4] = '{len: 255, beats: {4{15'h0001}},                            exp_res: 32'd255, exp_ovf: 1'b0};

    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.len = '0; bus0.abort = 1'b0; bus0.in_valid = 1'b0;
    bus0.apc_stream = '0; bus0.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.len = '0; bus1.abort = 1'b0; bus1.in_valid = 1'b0;
    bus1.apc_stream = '0; bus1.out_ready = 1'b0;
    #12;
    check("reset in_ready", 32'(bus0.in_ready), 32'd0);
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset result", 32'(bus0.result), 32'd0);
    check("reset overflow", 32'(bus0.overflow), 32'd0);
    tick();
    rst_n = 1'b1;

    // ---- table: basic jobs, incl. len=3 example and full-scale len=255 ----
    for (int v = 0; v < 5; v++)
      run_job0(vecs[v].len, vecs[v].beats, vecs[v].exp_res, vecs[v].exp_ovf);

    // ---- stalls: len=4 all-ones with 2 idle cycles between beats -> 60 ----
    bus0.len = 8'd4; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus0.apc_stream = 15'h7FFF;
      bus0.in_valid   = 1'b1;
      tick();
      bus0.in_valid = 1'b0;
      if (b < 3) begin
        for (int s = 0; s < 2; s++) begin
          tick();
          check("stall busy", 32'(bus0.busy), 32'd1);
          check("stall in_ready", 32'(bus0.in_ready), 32'd1);
        end
      end
    end
    check("stall drain", 32'(bus0.out_valid), 32'd0);
    tick();
    check("stall out_valid", 32'(bus0.out_valid), 32'd1);
    check("stall result", 32'(bus0.result), 32'd60);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;

    // ---- abort in the cycle after beat 2 of a len=10 job ----
    bus0.len = 8'd10; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.apc_stream = 15'h7FFF;
    bus0.in_valid   = 1'b1;
    tick();
    tick();
    bus0.abort = 1'b1;          // beat still offered: abort must win
    tick();
    bus0.abort = 1'b0;
    bus0.in_valid = 1'b0;
    check("abort busy", 32'(bus0.busy), 32'd0);
    check("abort in_ready", 32'(bus0.in_ready), 32'd0);
    check("abort result", 32'(bus0.result), 32'd0);
    tick();
    check("abort no late add", 32'(bus0.result), 32'd0);
    run_job0(1, {4{15'h00FF}}, 32'd8, 1'b0);

    // ---- result holding: len=1 beat 0x0007, out_ready low 5 cycles ----
    bus0.len = 8'd1; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.apc_stream = 15'h0007; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    bus0.len = 8'd5; bus0.start = 1'b1;   // must be ignored in DONE
    for (int c = 0; c < 5; c++) begin
      check("hold out_valid", 32'(bus0.out_valid), 32'd1);
      check("hold result", 32'(bus0.result), 32'd3);
      tick();
    end
    bus0.start = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    check("hold release out_valid", 32'(bus0.out_valid), 32'd0);
    check("hold release busy", 32'(bus0.busy), 32'd0);
    check("hold result kept in idle", 32'(bus0.result), 32'd3);

    // ---- saturation on dut1 (ACC_W=6): 5 x 15 = 75 -> 63 ----
    bus1.len = 8'd5; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bus1.apc_stream = 15'h7FFF; bus1.in_valid = 1'b1;
    repeat (5) tick();
    bus1.in_valid = 1'b0;
    tick();
    check("sat out_valid", 32'(bus1.out_valid), 32'd1);
    check("sat result", 32'(bus1.result), 32'd63);
    check("sat overflow", 32'(bus1.overflow), 32'd1);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("sat overflow sticky in idle", 32'(bus1.overflow), 32'd1);
    bus1.len = 8'd1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("sat overflow cleared by start", 32'(bus1.overflow), 32'd0);
    bus1.apc_stream = 15'h0003; bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    check("post-sat result", 32'(bus1.result), 32'd2);
    check("post-sat overflow", 32'(bus1.overflow), 32'd0);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;

    // ---- reset mid-RUN, then start with len=0 ----
    bus0.len = 8'd5; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.apc_stream = 15'h7FFF; bus0.in_valid = 1'b1;
    repeat (2) tick();
    bus0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", 32'(bus0.in_ready), 32'd0);
    check("mid reset busy", 32'(bus0.busy), 32'd0);
    check("mid reset out_valid", 32'(bus0.out_valid), 32'd0);
    check("mid reset result", 32'(bus0.result), 32'd0);
    check("mid reset overflow", 32'(bus0.overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    bus0.len = 8'd0; bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    check("len0 busy", 32'(bus0.busy), 32'd0);
    check("len0 in_ready", 32'(bus0.in_ready), 32'd0);
    run_job0(1, {4{15'h7FFF}}, 32'd15, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_apc_accum
